// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the funct3 op encoding, the sequencer state encoding and the RV32M special-result constants.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam logic [MDU_XLEN-1:0] MDU_DIV_Z_Q = '1;
    localparam logic [MDU_XLEN-1:0] MDU_INT_MIN = {1'b1, {(MDU_XLEN-1){1'b0}}};

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
// The pipeline is the master; the sequencer is the slave.
interface mul_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             isMulE;
    logic             abort;
    logic [2:0]       funct3E;
    logic [WIDTH-1:0] opAE;
    logic [WIDTH-1:0] opBE;
    logic             busy;
    logic             isDone;
    logic [WIDTH-1:0] mulResE;

    modport master (
        output isMulE, abort, funct3E, opAE, opBE,
        input  busy, isDone, mulResE
    );

    modport slave (
        input  isMulE, abort, funct3E, opAE, opBE,
        output busy, isDone, mulResE
    );
endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration of the multiply (shift-add) or restoring divide, purely combinational.
// Multiply: {hi,lo} is the product register, lo starts as the multiplier. Divide: hi is the remainder, lo the quotient.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_m};
        o_hi    = '0;
        o_lo    = '0;
        if (i_is_div) begin
            // Remainder stays below the divisor, so a non-negative trial always fits in WIDTH bits.
            if (!w_trial[WIDTH]) begin
                o_hi = w_trial[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {o_hi, o_lo} = {w_sum, i_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide unit for the Execute stage: WIDTH radix-2 steps, then a one-cycle isDone pulse.
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiplies, divide-by-zero and signed overflow go straight to DONE.
//
// state | meaning
// IDLE  | waiting for isMulE; operands latched on the start edge
// BUSY  | one iteration per clock, counter counts WIDTH down to 1
// DONE  | result valid, isDone high for one cycle, then IDLE
module mul_div_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mul_div_sequencer_if.slave mdu
);
    localparam int               CW      = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] DIV_Z_Q = '1;

    mdu_state_t         r_state, w_state_nxt;
    mdu_op_t            r_op, w_op;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_res, r_neg_rem, r_b_zero;
    logic [WIDTH-1:0]   r_hi, r_lo, r_m, r_res;

    logic               w_start, w_finish, w_early_hit, w_is_div;
    logic               w_a_signed, w_b_signed;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_early_res;
    logic [WIDTH-1:0]   w_step_hi, w_step_lo, w_quo, w_rem, w_final;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_op       = mdu_op_t'(mdu.funct3E);
        w_is_div   = mdu_is_div(w_op);
        w_a_signed = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && mdu.opAE[WIDTH-1];
        w_b_signed = (w_op inside {OP_MULH, OP_DIV, OP_REM}) && mdu.opBE[WIDTH-1];
        w_a_mag    = w_a_signed ? -mdu.opAE : mdu.opAE;
        w_b_mag    = w_b_signed ? -mdu.opBE : mdu.opBE;
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_early_hit = 1'b0;
        w_early_res = '0;
        if (w_is_div) begin
            if (mdu.opBE == '0) begin
                w_early_hit = 1'b1;
                w_early_res = (w_op inside {OP_DIV, OP_DIVU}) ? DIV_Z_Q : mdu.opAE;
            end else if ((w_op inside {OP_DIV, OP_REM}) && (mdu.opAE == INT_MIN) && (mdu.opBE == '1)) begin
                w_early_hit = 1'b1;
                w_early_res = (w_op == OP_DIV) ? INT_MIN : '0;
            end
        end else if ((mdu.opAE == '0) || (mdu.opBE == '0)) begin
            w_early_hit = 1'b1;
        end
    end
`else
    assign w_early_hit = 1'b0;
    assign w_early_res = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mdu.isMulE && !mdu.abort) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_early_hit ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (mdu.abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                    w_finish    = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (mdu_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_m      (r_m),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Sign fix-up on the last iteration's output so the result lands on the BUSY->DONE edge.
    always_comb begin
        w_prod = r_neg_res ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
        w_quo  = r_b_zero ? DIV_Z_Q : (r_neg_res ? -w_step_lo : w_step_lo);
        w_rem  = r_neg_rem ? -w_step_hi : w_step_hi;
        case (r_op)
            OP_MUL:                       w_final = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_final = w_quo;
            default:                      w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_m       <= '0;
            r_res     <= '0;
        end else if (w_start) begin
            r_op      <= w_op;
            r_cnt     <= w_early_hit ? '0 : CW'(WIDTH);
            r_neg_res <= w_a_signed ^ w_b_signed;
            r_neg_rem <= w_a_signed;
            r_b_zero  <= (mdu.opBE == '0);
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            r_m       <= w_is_div ? w_b_mag : w_a_mag;
            if (w_early_hit) r_res <= w_early_res;
        end else if (r_state == BUSY) begin
            if (mdu.abort) begin
                r_cnt <= '0;
            end else begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt - CW'(1);
                if (w_finish) r_res <= w_final;
            end
        end
    end

    assign mdu.busy    = (r_state != IDLE);
    assign mdu.isDone  = (r_state == DONE) && !mdu.abort;
    assign mdu.mulResE = r_res;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: timestamp-based reference model compared every cycle,
// directed RV32M corner cases with literal results, abort/reset scenarios and randomized traffic.
module tb_mul_div_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] INT_MIN = 32'h8000_0000;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    mul_div_sequencer_if #(.WIDTH(W)) mdu_bus ();

    mul_div_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        int          ia, ib;
        ia = a;
        ib = b;
        sa = longint'(ia);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin sb = longint'(ib); p = sa * sb; return p[63:32]; end
            3'd2: begin sb = longint'({32'b0, b}); p = sa * sb; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the start edge until the result edge.
    function automatic int op_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit early;
        if (f[2]) early = (b == 0) || ((f == 3'd4 || f == 3'd6) && a == INT_MIN && b == 32'hFFFF_FFFF);
        else      early = (a == 0) || (b == 0);
        return (EARLY && early) ? 0 : W;
    endfunction

    // Reference model: an op accepted on edge s completes on edge s+lat, returns to idle one edge later.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_done_cyc = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res = '0;
    int          n_model_done = 0;
    int          n_dut_done = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 1'b0;
            m_res    = '0;
        end else begin
            cyc++;
            if (m_active) begin
                if (mdu_bus.abort)              m_active = 1'b0;
                else if (cyc == m_done_cyc)     m_res = m_pend;
                else if (cyc == m_done_cyc + 1) m_active = 1'b0;
            end else if (mdu_bus.isMulE && !mdu_bus.abort) begin
                m_active   = 1'b1;
                m_done_cyc = cyc + op_lat(mdu_bus.funct3E, mdu_bus.opAE, mdu_bus.opBE);
                m_pend     = ref_res(mdu_bus.funct3E, mdu_bus.opAE, mdu_bus.opBE);
                if (m_done_cyc == cyc) m_res = m_pend;
            end
        end
    end

    initial forever begin
        bit exp_done;
        @(negedge clk);
        exp_done = m_active && !rst && (cyc == m_done_cyc) && !mdu_bus.abort;
        if (exp_done)       n_model_done++;
        if (mdu_bus.isDone) n_dut_done++;
        chk("cyc_busy",   {31'b0, mdu_bus.busy},   {31'b0, m_active});
        chk("cyc_isDone", {31'b0, mdu_bus.isDone}, {31'b0, exp_done});
        chk("cyc_result", mdu_bus.mulResE, m_res);
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return INT_MIN;
            3:       return 32'($urandom_range(1, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int          first;
        int          pulses;
        logic [31:0] res_at;
        chk({nm, "_model"}, ref_res(f, a, b), exp);
        @(posedge clk); #1;
        mdu_bus.isMulE = 1'b1; mdu_bus.funct3E = f; mdu_bus.opAE = a; mdu_bus.opBE = b;
        @(posedge clk); #1;
        mdu_bus.isMulE = 1'b0; mdu_bus.funct3E = 3'($urandom); mdu_bus.opAE = $urandom; mdu_bus.opBE = $urandom;
        first = -1; pulses = 0; res_at = '0;
        for (int n = 0; n < W + 4; n++) begin
            @(negedge clk);
            if (mdu_bus.isDone) begin
                pulses++;
                if (first < 0) begin first = n; res_at = mdu_bus.mulResE; end
            end
        end
        chk({nm, "_latency"}, first, op_lat(f, a, b));
        chk({nm, "_pulses"},  pulses, 1);
        chk({nm, "_result"},  res_at, exp);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs [13];
    logic [31:0] last_res;
    int          pulses;

    initial begin
        vecs[0]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_m7_2"};
        vecs[1]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_m7_2"};
        vecs[2]  = '{3'd5, 32'd100,       32'd7,        32'd14,        "divu_100_7"};
        vecs[3]  = '{3'd7, 32'd100,       32'd7,        32'd2,         "remu_100_7"};
        vecs[4]  = '{3'd4, 32'd12345,     32'd0,        32'hFFFF_FFFF, "div_by_0"};
        vecs[5]  = '{3'd6, 32'd5,         32'd0,        32'd5,         "rem_by_0"};
        vecs[6]  = '{3'd4, INT_MIN,       32'hFFFF_FFFF, INT_MIN,      "div_ovf"};
        vecs[7]  = '{3'd6, INT_MIN,       32'hFFFF_FFFF, 32'd0,        "rem_ovf"};
        vecs[8]  = '{3'd0, 32'd0,         32'd1234,     32'd0,         "mul_zero"};
        vecs[9]  = '{3'd1, INT_MIN,       INT_MIN,      32'h4000_0000, "mulh_min"};
        vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1"};
        vecs[11] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};

        mdu_bus.isMulE = 1'b0; mdu_bus.abort = 1'b0; mdu_bus.funct3E = 3'd0;
        mdu_bus.opAE = '0; mdu_bus.opBE = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   {31'b0, mdu_bus.busy},   32'd0);
        chk("reset_isDone", {31'b0, mdu_bus.isDone}, 32'd0);
        chk("reset_result", mdu_bus.mulResE,          32'd0);
        @(posedge clk); #1 rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
        last_res = vecs[12].exp;

        // Abort seen on the tenth BUSY edge.
        @(posedge clk); #1;
        mdu_bus.isMulE = 1'b1; mdu_bus.funct3E = 3'd5; mdu_bus.opAE = 32'd1000; mdu_bus.opBE = 32'd3;
        @(posedge clk); #1 mdu_bus.isMulE = 1'b0;
        repeat (9) @(posedge clk);
        #1 mdu_bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", {31'b0, mdu_bus.busy}, 32'd1);
        @(posedge clk); #1 mdu_bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", {31'b0, mdu_bus.busy}, 32'd0);
        pulses = 0;
        for (int n = 0; n < W + 4; n++) begin
            @(negedge clk);
            if (mdu_bus.isDone) pulses++;
        end
        chk("abort_no_done",  pulses, 0);
        chk("abort_res_kept", mdu_bus.mulResE, last_res);

        @(posedge clk); #1 mdu_bus.isMulE = 1'b1; mdu_bus.abort = 1'b1;
        @(posedge clk); #1 mdu_bus.isMulE = 1'b0; mdu_bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", {31'b0, mdu_bus.busy}, 32'd0);

        // Reset mid-BUSY, then back-to-back ops with isMulE held high.
        @(posedge clk); #1;
        mdu_bus.isMulE = 1'b1; mdu_bus.funct3E = 3'd0; mdu_bus.opAE = 32'd99; mdu_bus.opBE = 32'd77;
        @(posedge clk); #1 mdu_bus.isMulE = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy",   {31'b0, mdu_bus.busy}, 32'd0);
        chk("rst_mid_result", mdu_bus.mulResE,        32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mdu_bus.isMulE = 1'b1;
        mdu_bus.funct3E = 3'($urandom); mdu_bus.opAE = rnd_val(); mdu_bus.opBE = rnd_val();
        pulses = 0;
        for (int n = 0; n < 3 * (W + 2) + 1; n++) begin
            @(negedge clk);
            if (mdu_bus.isDone) pulses++;
            @(posedge clk); #1;
            mdu_bus.funct3E = 3'($urandom); mdu_bus.opAE = rnd_val(); mdu_bus.opBE = rnd_val();
        end
        mdu_bus.isMulE = 1'b0;
        chk("b2b_pulses", pulses, 3);
        repeat (W + 6) @(posedge clk);

        // Randomized traffic with occasional aborts and operand churn while busy.
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            mdu_bus.isMulE  = 1'b1;
            mdu_bus.abort   = ($urandom_range(0, 11) == 0);
            mdu_bus.funct3E = 3'($urandom);
            mdu_bus.opAE    = rnd_val();
            mdu_bus.opBE    = rnd_val();
            @(posedge clk); #1;
            mdu_bus.isMulE = 1'b0;
            mdu_bus.abort  = 1'b0;
            repeat ($urandom_range(0, W + 4)) begin
                mdu_bus.opAE  = $urandom;
                mdu_bus.opBE  = $urandom;
                mdu_bus.abort = ($urandom_range(0, 39) == 0);
                @(posedge clk); #1;
            end
            mdu_bus.abort = 1'b0;
        end
        repeat (W + 6) @(posedge clk);
        @(negedge clk);
        chk("done_count", n_dut_done, n_model_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
